spi_shift_engine: RTL
=====================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per frame (legal 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port tx_data  input  DATA_WIDTH  frame to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port tx_ready  output  1  engine accepts a frame.
REQ-008 SHALL have port rx_data  output  DATA_WIDTH  received frame.
REQ-009 SHALL have port rx_valid  output  1  rx_data valid; held until accepted.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-011 SHALL have port send_tick  input  1  one-cycle pulse from clock generator: drive next bit.
REQ-012 SHALL have port recv_tick  input  1  one-cycle pulse from clock generator: sample input bit.
REQ-013 SHALL have port clk_en  output  1  enables the SPI clock generator.
REQ-014 SHALL have port sdo  output  1  serial data out.
REQ-015 SHALL have port sdi  input  1  serial data in.
REQ-016 SHALL have port busy  output  1  frame in progress (state != IDLE).

Function
REQ-017 SHALL implement states IDLE, SHIFT, DONE.
REQ-018 tx_ready SHALL be 1 only in IDLE with rx_valid == 0; no frame starts while an unread rx frame is held.
REQ-019 On tx_valid && tx_ready at edge T: load tx shift register, clear bit count, enter SHIFT; clk_en = 1 from T+1.
REQ-020 In SHIFT, each send_tick SHALL set sdo to the next bit in configured order; the first send_tick drives bit DATA_WIDTH-1 (MSB_FIRST=1) or bit 0.
REQ-021 In SHIFT, each recv_tick SHALL shift the sampled input into the rx shift register and increment the bit count.
REQ-022 send_tick and recv_tick in the same cycle SHALL both take effect; the sample uses sdi, not the new sdo.
REQ-023 Ticks in IDLE or DONE SHALL be ignored.
REQ-024 On the DATA_WIDTH-th recv_tick: enter DONE; clk_en = 0 in the following cycle.
REQ-025 DONE SHALL last one cycle, set rx_data to the assembled frame, set rx_valid = 1, and return to IDLE.
REQ-026 rx_valid SHALL clear on the cycle after rx_valid && rx_ready; rx_data holds until the next frame completes.
REQ-027 Per-frame latency SHALL be: handshake edge -> clk_en high 1 cycle; last recv_tick -> rx_valid high 2 cycles.
REQ-028 sdo SHALL hold its last driven bit between ticks and SHALL return to 0 on entry to IDLE.
REQ-029 Bit count SHALL be $clog2(DATA_WIDTH+1) bits wide; it never wraps within a frame.

Reset
REQ-030 reset SHALL force state IDLE, clk_en 0, sdo 0, rx_valid 0, rx_data 0, busy 0, and shift registers 0.
REQ-031 tx_ready SHALL be 0 during reset and 1 in the cycle after reset deasserts.
REQ-032 reset asserted mid-frame SHALL discard the partial frame; no rx_valid results.

Configuration
REQ-033 Macro SPI_SHIFT_ENGINE_LOOPBACK_EN SHALL be the only compile option.
REQ-034 With SPI_SHIFT_ENGINE_LOOPBACK_EN defined, the module SHALL add input port loopback (1 bit); when loopback = 1, recv_tick samples the current sdo instead of sdi.
REQ-035 Without SPI_SHIFT_ENGINE_LOOPBACK_EN, port loopback SHALL not exist and sampling always uses sdi.

Structure
REQ-036 Package spi_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the constant SPI_DEFAULT_DATA_WIDTH = 8.
REQ-037 The block SHALL be a single module with no sub-module; the clock generator stays external and is driven through clk_en, send_tick and recv_tick.

Verification
REQ-038 Basic frame: MSB_FIRST=1; tx_data=0xA5; sdi driven by a slave returning 0x3C; ticks every 16 cycles -> sdo sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid 2 cycles after the 8th recv_tick.
REQ-039 LSB first: MSB_FIRST=0; tx_data=0x01 -> sdo 1 then seven 0s; sdi=0x80 sent LSB first -> rx_data=0x80.
REQ-040 Backpressure: rx_ready=0 after frame 1 -> tx_ready stays 0 with tx_valid=1; rx_ready=1 for one cycle -> frame 2 starts on the next handshake.
REQ-041 Reset mid-frame: reset after the 4th recv_tick -> next cycle clk_en=0, sdo=0, busy=0; rx_valid never asserts.
REQ-042 Simultaneous ticks: send_tick and recv_tick together on every bit, sdi tied 1 -> rx_data=0xFF; sdo matches tx_data.
REQ-043 Loopback (macro defined): loopback=1, tx_data=0x5A, sdi=0 -> rx_data=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: frame FSM states and default frame width.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam int SPI_DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises tx_data onto sdo and assembles rx_data from sdi under external ticks.
// Optional build macro SPI_SHIFT_ENGINE_LOOPBACK_EN adds a loopback input that samples sdo instead of sdi.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic                  send_tick,
  input  logic                  recv_tick,
  output logic                  clk_en,
  output logic                  sdo,
  input  logic                  sdi,
`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  start;
  logic                  send_en;
  logic                  recv_en;
  logic                  last_bit;
  logic                  sample;

`ifdef SPI_SHIFT_ENGINE_LOOPBACK_EN
  assign sample = loopback ? sdo : sdi;
`else
  assign sample = sdi;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    clk_en    = 1'b0;
    busy      = 1'b1;
    send_en   = 1'b0;
    recv_en   = 1'b0;
    last_bit  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        // No new frame may overwrite a received frame the consumer has not taken.
        tx_ready = !rx_valid && !reset;
        start    = tx_valid && tx_ready;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        clk_en   = 1'b1;
        send_en  = send_tick;
        recv_en  = recv_tick;
        last_bit = recv_tick && (bit_cnt == LAST_BIT);
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      sdo      <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (start) begin
        tx_sr   <= tx_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end

      // A same-cycle send and receive both act; the sample sees the pre-edge sdo/sdi.
      if (send_en) begin
        if (MSB_FIRST) begin
          sdo   <= tx_sr[DATA_WIDTH-1];
          tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
        end else begin
          sdo   <= tx_sr[0];
          tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
        end
      end

      if (recv_en) begin
        if (MSB_FIRST) begin
          rx_sr <= {rx_sr[DATA_WIDTH-2:0], sample};
        end else begin
          rx_sr <= {sample, rx_sr[DATA_WIDTH-1:1]};
        end
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state == DONE) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
        sdo      <= 1'b0;
      end
    end
  end

endmodule
